// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// the hard-wired zero register and the default memory timeout.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam logic [4:0]  REG_ZERO        = 5'd0;
    localparam int unsigned MEM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use hazard compare between ID/EX and IF/ID.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    output logic       load_use
);

    // $0 is hard-wired to zero, so a load targeting it never creates a dependency.
    assign load_use = idex_mem_read && (idex_rt != REG_ZERO) &&
                      ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline with multi-cycle dmem sequencing.
// Optional stall-cycle counter enabled by defining PIPE_HAZARD_STALL_CNT_EN.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned TO_W        = 8,
    parameter int unsigned CNT_W       = 16
)
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_Rt_i,
    input  logic [4:0]       IFID_Rs_i,
    input  logic [4:0]       IFID_Rt_i,
    input  logic             Branch_taken_i,
    input  logic             Jump_i,
    input  logic             EXMEM_MemRead_i,
    input  logic             EXMEM_MemWrite_i,
    input  logic             dmem_ack_i,
    output logic             dmem_req_o,
    output logic             PC_write_o,
    output logic             IFID_write_o,
    output logic             IFID_flush_o,
    output logic             IDEX_bubble_o,
    output logic             EXMEM_hold_o,
    output logic             MEMWB_bubble_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    state_t          state, state_nxt;
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
    logic            err_q;
    logic            mem_access;
    logic            mem_stall;
    logic            load_use;

    assign mem_access = EXMEM_MemRead_i | EXMEM_MemWrite_i;

    hazard_detect u_hazard_detect (
        .idex_mem_read (IDEX_MemRead_i),
        .idex_rt       (IDEX_Rt_i),
        .ifid_rs       (IFID_Rs_i),
        .ifid_rt       (IFID_Rt_i),
        .load_use      (load_use)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            to_cnt <= to_cnt_nxt;
            if (state_nxt == ST_ERR)
                err_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        to_cnt_nxt = to_cnt;
        case (state)
            ST_IDLE: begin
                if (mem_access && !dmem_ack_i) begin
                    state_nxt  = ST_WAIT;
                    to_cnt_nxt = TO_W'(1);
                end
            end
            ST_WAIT: begin
                // to_cnt counts WAIT cycles spent so far; MEM_TIMEOUT of them trips ERR.
                if (dmem_ack_i) begin
                    state_nxt  = ST_IDLE;
                    to_cnt_nxt = '0;
                end else if (to_cnt == TO_W'(MEM_TIMEOUT)) begin
                    state_nxt  = ST_ERR;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end
            end
            ST_ERR:  state_nxt = ST_ERR;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_stall = ((state == ST_IDLE) && mem_access && !dmem_ack_i) ||
                    ((state == ST_WAIT) && !dmem_ack_i) ||
                    (state == ST_ERR);

        dmem_req_o     = 1'b0;
        PC_write_o     = 1'b1;
        IFID_write_o   = 1'b1;
        IFID_flush_o   = 1'b0;
        IDEX_bubble_o  = 1'b0;
        EXMEM_hold_o   = 1'b0;
        MEMWB_bubble_o = 1'b0;

        case (state)
            ST_IDLE: dmem_req_o = mem_access;
            ST_WAIT: dmem_req_o = 1'b1;
            default: dmem_req_o = 1'b0;
        endcase

        // Priority: memory freeze, then load-use bubble, then control-flow flush.
        if (mem_stall) begin
            PC_write_o     = 1'b0;
            IFID_write_o   = 1'b0;
            EXMEM_hold_o   = 1'b1;
            MEMWB_bubble_o = 1'b1;
        end else if (load_use) begin
            PC_write_o     = 1'b0;
            IFID_write_o   = 1'b0;
            IDEX_bubble_o  = 1'b1;
        end else if (Branch_taken_i || Jump_i) begin
            IFID_flush_o   = 1'b1;
        end

        if (rst_i) begin
            dmem_req_o     = 1'b0;
            PC_write_o     = 1'b0;
            IFID_write_o   = 1'b0;
            IFID_flush_o   = 1'b0;
            IDEX_bubble_o  = 1'b0;
            EXMEM_hold_o   = 1'b0;
            MEMWB_bubble_o = 1'b0;
        end
    end

    assign err_o = err_q;

`ifdef PIPE_HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            stall_cnt <= '0;
        else if (!PC_write_o && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        idex_mem_read;
    logic [4:0]  idex_rt, ifid_rs, ifid_rt;
    logic        branch_taken, jump;
    logic        exmem_mem_read, exmem_mem_write, dmem_ack;
    logic        dmem_req, pc_write, ifid_write, ifid_flush;
    logic        idex_bubble, exmem_hold, memwb_bubble, err;
    logic [15:0] stall_cnt;
    logic [7:0]  outs;

    int checks = 0;
    int errors = 0;

    // {dmem_req, pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, memwb_bubble, err}
    localparam logic [7:0] V_RST = 8'b0000_0000;
    localparam logic [7:0] V_DEF = 8'b0110_0000;
    localparam logic [7:0] V_LU  = 8'b0000_1000;
    localparam logic [7:0] V_FL  = 8'b0111_0000;
    localparam logic [7:0] V_MS  = 8'b1000_0110;
    localparam logic [7:0] V_ACK = 8'b1110_0000;
    localparam logic [7:0] V_ERR = 8'b0000_0111;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .TO_W(8), .CNT_W(16)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .IDEX_MemRead_i   (idex_mem_read),
        .IDEX_Rt_i        (idex_rt),
        .IFID_Rs_i        (ifid_rs),
        .IFID_Rt_i        (ifid_rt),
        .Branch_taken_i   (branch_taken),
        .Jump_i           (jump),
        .EXMEM_MemRead_i  (exmem_mem_read),
        .EXMEM_MemWrite_i (exmem_mem_write),
        .dmem_ack_i       (dmem_ack),
        .dmem_req_o       (dmem_req),
        .PC_write_o       (pc_write),
        .IFID_write_o     (ifid_write),
        .IFID_flush_o     (ifid_flush),
        .IDEX_bubble_o    (idex_bubble),
        .EXMEM_hold_o     (exmem_hold),
        .MEMWB_bubble_o   (memwb_bubble),
        .err_o            (err),
        .stall_cnt_o      (stall_cnt)
    );

    assign outs = {dmem_req, pc_write, ifid_write, ifid_flush,
                   idex_bubble, exmem_hold, memwb_bubble, err};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        @(negedge clk);
        check(tag, {24'd0, outs}, {24'd0, exp});
    endtask

    task automatic clear_in();
        idex_mem_read   = 1'b0;
        idex_rt         = 5'd0;
        ifid_rs         = 5'd0;
        ifid_rt         = 5'd0;
        branch_taken    = 1'b0;
        jump            = 1'b0;
        exmem_mem_read  = 1'b0;
        exmem_mem_write = 1'b0;
        dmem_ack        = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        #2;
        check("reset_outs", {24'd0, outs}, {24'd0, V_RST});
        check("reset_cnt", {16'd0, stall_cnt}, 32'd0);

        next_cycle(); rst = 1'b0;
        chk("idle_default", V_DEF);

        // load-use via rs, bubble lasts one cycle
        next_cycle(); idex_mem_read = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
        chk("lu_rs", V_LU);
        next_cycle(); clear_in(); ifid_rs = 5'd8;
        chk("lu_after", V_DEF);

        next_cycle(); idex_mem_read = 1'b1; idex_rt = 5'd9; ifid_rt = 5'd9;
        chk("lu_rt", V_LU);

        next_cycle(); clear_in(); idex_mem_read = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
        chk("lu_reg0", V_DEF);

        next_cycle(); clear_in(); idex_rt = 5'd8; ifid_rs = 5'd8;
        chk("no_load", V_DEF);

        next_cycle(); clear_in(); branch_taken = 1'b1;
        chk("branch_flush", V_FL);
        next_cycle(); clear_in(); jump = 1'b1;
        chk("jump_flush", V_FL);

        next_cycle(); clear_in(); idex_mem_read = 1'b1; idex_rt = 5'd4; ifid_rs = 5'd4; branch_taken = 1'b1;
        chk("lu_over_branch", V_LU);

        // load with ack three cycles later; hazards raised during the wait
        next_cycle(); clear_in(); exmem_mem_read = 1'b1;
        chk("ld_req0", V_MS);
        next_cycle(); idex_mem_read = 1'b1; idex_rt = 5'd3; ifid_rs = 5'd3; branch_taken = 1'b1;
        chk("ld_wait1_hz", V_MS);
        next_cycle();
        chk("ld_wait2_hz", V_MS);
        next_cycle(); clear_in(); exmem_mem_read = 1'b1; dmem_ack = 1'b1;
        chk("ld_ack", V_ACK);
        next_cycle(); clear_in();
        chk("ld_idle", V_DEF);

        // zero-wait store
        next_cycle(); exmem_mem_write = 1'b1; dmem_ack = 1'b1;
        chk("st_zero_wait", V_ACK);
        next_cycle(); clear_in();
        chk("st_idle", V_DEF);

        // timeout into ERR
        next_cycle(); exmem_mem_read = 1'b1;
        chk("to_req", V_MS);
        for (int unsigned i = 1; i <= 4; i++) begin
            next_cycle();
            chk($sformatf("to_wait%0d", i), V_MS);
        end
        next_cycle();
        chk("to_err", V_ERR);
        next_cycle(); dmem_ack = 1'b1;
        chk("err_sticky", V_ERR);

        // asynchronous reset in the middle of a cycle
        #2 rst = 1'b1;
        #1;
        check("async_rst", {24'd0, outs}, {24'd0, V_RST});
        next_cycle(); rst = 1'b0; clear_in();
        chk("post_rst", V_DEF);
        check("stall_cnt_end", {16'd0, stall_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers, plus PC).
- Detects load-use hazards and taken branches/jumps resolved in ID.
- Sequences the multi-cycle data-memory access of the instruction in EX/MEM, freezing the pipeline until the memory acknowledges.
- Drives per-register write-enable, bubble and flush controls; the pipeline registers gain enable/bubble inputs driven from here.

Parameters:
- MEM_TIMEOUT, 16, max cycles in WAIT before entering ERR. Range 2..255.
- TO_W, 8, width of the timeout counter. Must satisfy 2^TO_W > MEM_TIMEOUT.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- IDEX_MemRead_i  in  1  instruction in ID/EX is a load.
- IDEX_Rt_i  in  5  load destination register in ID/EX.
- IFID_Rs_i  in  5  rs of the instruction in IF/ID.
- IFID_Rt_i  in  5  rt of the instruction in IF/ID.
- Branch_taken_i  in  1  branch resolved taken in ID.
- Jump_i  in  1  jump decoded in ID.
- EXMEM_MemRead_i  in  1  load in the MEM stage.
- EXMEM_MemWrite_i  in  1  store in the MEM stage.
- dmem_ack_i  in  1  data memory access complete; valid only while a request is outstanding.
- dmem_req_o  out  1  data memory request strobe.
- PC_write_o  out  1  PC load enable.
- IFID_write_o  out  1  IF/ID load enable.
- IFID_flush_o  out  1  clear IF/ID to NOP.
- IDEX_bubble_o  out  1  zero ID/EX control fields (WB, M, EX).
- EXMEM_hold_o  out  1  EX/MEM keeps its current value.
- MEMWB_bubble_o  out  1  zero MEM/WB WB control fields.
- err_o  out  1  sticky memory-timeout error.
- stall_cnt_o  out  CNT_W  stall-cycle counter (see Optional Feature).

Behaviour:
- FSM states: IDLE, WAIT, ERR. A timeout counter to_cnt (TO_W bits) is used in WAIT.
- Reset (async, immediate): state=IDLE, to_cnt=0, err_o=0, stall_cnt_o=0. While rst_i is high all combinational outputs are forced: PC_write_o=0, IFID_write_o=0, dmem_req_o=0, flushes/bubbles=0, EXMEM_hold_o=0.
- mem_access = EXMEM_MemRead_i | EXMEM_MemWrite_i.
- mem_stall = (IDLE & mem_access & ~dmem_ack_i) | (WAIT & ~dmem_ack_i) | ERR.
- IDLE:
  - dmem_req_o = mem_access.
  - mem_access & dmem_ack_i in the same cycle (zero-wait) -> no stall, stay IDLE.
  - mem_access & ~dmem_ack_i -> WAIT, to_cnt=1.
- WAIT:
  - dmem_req_o=1.
  - dmem_ack_i -> IDLE. Hold is released in the ack cycle, so at that edge EX/MEM advances and MEM/WB captures the load data.
  - Otherwise to_cnt += 1; when to_cnt == MEM_TIMEOUT -> ERR.
- ERR: dmem_req_o=0, err_o=1, full freeze. Only rst_i exits ERR.
- Stall/flush priority: mem_stall > load-use > branch/jump flush.
- mem_stall:
  - PC_write_o=0, IFID_write_o=0, EXMEM_hold_o=1, MEMWB_bubble_o=1.
  - ID/EX holds, implemented as IDEX_bubble_o=0 plus ID/EX enable tied to ~EXMEM_hold_o.
  - IFID_flush_o=0.
- load_use = IDEX_MemRead_i & (IDEX_Rt_i != 0) & (IDEX_Rt_i == IFID_Rs_i | IDEX_Rt_i == IFID_Rt_i).
  - On load_use: PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1 for exactly one cycle.
  - Branch_taken_i/Jump_i are ignored in that cycle and re-evaluated the next cycle.
- Flush: on (Branch_taken_i | Jump_i) with no higher-priority condition: IFID_flush_o=1, PC_write_o=1.
- Default (no hazard): PC_write_o=1, IFID_write_o=1, all flushes/bubbles/holds 0.
- Register $0 never causes a load-use stall.

Optional Feature:
- Macro: PIPE_HAZARD_STALL_CNT_EN.
- Defined: stall_cnt_o increments (saturating at all-ones) on every cycle where PC_write_o=0 and rst_i=0.
- Undefined: stall_cnt_o is tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding constants: ST_IDLE=2'd0, ST_WAIT=2'd1, ST_ERR=2'd2;
  - REG_ZERO=5'd0;
  - default MEM_TIMEOUT.
- One natural sub-module, hazard_detect: the combinational load_use compare, reused by the forwarding unit tests.

Test Plan:
- IDEX_MemRead_i=1, IDEX_Rt_i=8, IFID_Rs_i=8 -> one cycle with PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1; next cycle all defaults.
- Same as above with IDEX_Rt_i=0 -> no stall.
- EXMEM_MemRead_i=1, dmem_ack_i asserted 3 cycles later -> dmem_req_o=1 for 4 cycles; EXMEM_hold_o=1 for 3 cycles, 0 in the ack cycle; state back to IDLE.
- Store with dmem_ack_i in the same cycle -> no stall cycle, dmem_req_o pulses 1 cycle.
- Load-use, Branch_taken_i and WAIT all active together -> only mem-stall controls asserted; IFID_flush_o=0 until the stall clears.
- dmem_ack_i never asserted, MEM_TIMEOUT=4 -> ERR reached 4 cycles after entering WAIT, err_o=1 and frozen. Assert rst_i mid-ERR -> outputs reset immediately, without waiting for a clock edge.
